// File: rtl/gcn_pkg.sv
// Shared dimensions, types and helpers for the GCN aggregation stage.
// Edge endpoints are 1-based node numbers; FM_WM rows are 0-based.
package gcn_pkg;

    localparam int FEATURE_ROWS = 6;
    localparam int WEIGHT_COLS = 3;
    localparam int DOT_PROD_WIDTH = 16;
    localparam int NUM_EDGES = 6;
    localparam int COO_BW = 3;
    localparam int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS);
    localparam int EDGE_ADDR_WIDTH = $clog2(NUM_EDGES);
    localparam int CLASS_WIDTH = $clog2(WEIGHT_COLS);

    typedef logic [DOT_PROD_WIDTH-1:0] dot_t;
    typedef dot_t [WEIGHT_COLS-1:0] fm_wm_row_t;
    // [1] = src node, [0] = dst node
    typedef logic [1:0][COO_BW-1:0] coo_pair_t;
    typedef logic [CLASS_WIDTH-1:0] class_t;
    typedef class_t [FEATURE_ROWS-1:0] class_vec_t;
    typedef logic [COUNTER_FEATURE_WIDTH-1:0] row_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        EDGE_SRC,
        EDGE_DST,
        ARGMAX,
        DONE
    } agg_state_t;

    function automatic logic node_ok(logic [COO_BW-1:0] idx);
        return (idx != '0) && (int'(idx) <= FEATURE_ROWS);
    endfunction

    function automatic row_idx_t node_row(logic [COO_BW-1:0] idx);
        return row_idx_t'(idx - COO_BW'(1));
    endfunction

    function automatic fm_wm_row_t add_row(fm_wm_row_t a, fm_wm_row_t b);
        fm_wm_row_t s;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            s[c] = a[c] + b[c];
        end
        return s;
    endfunction

endpackage

// File: rtl/aggregation_block_if.sv
// Read ports toward the FM_WM buffer and the COO edge memory.
// Both memories answer combinationally from the presented address.
interface aggregation_block_if;
    import gcn_pkg::*;

    row_idx_t read_row;
    fm_wm_row_t fm_wm_row_in;
    logic [EDGE_ADDR_WIDTH-1:0] coo_address;
    coo_pair_t coo_in;

    modport master (
        output read_row,
        output coo_address,
        input fm_wm_row_in,
        input coo_in
    );

    modport slave (
        input read_row,
        input coo_address,
        output fm_wm_row_in,
        output coo_in
    );

endinterface

// File: rtl/aggregation_block_argmax.sv
// Combinational argmax over one aggregated row.
// Strict compare keeps the lowest column on ties.
module row_argmax
    import gcn_pkg::*;
(
    input fm_wm_row_t row,
    output class_t idx
);

    dot_t best;

    always_comb begin
        best = row[0];
        idx = '0;
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (row[c] > best) begin
                best = row[c];
                idx = class_t'(c);
            end
        end
    end

endmodule

// File: rtl/aggregation_block.sv
// GCN aggregation: self-loop + bidirectional COO edge sums of FM_WM,
// followed by a per-node argmax class.
module aggregation_block
    import gcn_pkg::*;
(
    input logic clk,
    input logic reset,
    input logic start,
    aggregation_block_if.master mem,
    output logic done,
    output logic coo_err,
    output class_vec_t max_addi_answer
);

    agg_state_t state, state_n;
    row_idx_t row_cnt;
    logic [EDGE_ADDR_WIDTH-1:0] edge_cnt;
    fm_wm_row_t acc [FEATURE_ROWS];
    logic [COO_BW-1:0] src, dst;
    logic edge_ok, row_last, edge_last;
    class_t argmax_idx;

    assign src = mem.coo_in[1];
    assign dst = mem.coo_in[0];
    assign edge_ok = node_ok(src) && node_ok(dst);
    assign row_last = row_cnt == row_idx_t'(FEATURE_ROWS - 1);
    assign edge_last = edge_cnt == EDGE_ADDR_WIDTH'(NUM_EDGES - 1);
    assign mem.coo_address = edge_cnt;

    row_argmax u_argmax (
        .row (acc[row_cnt]),
        .idx (argmax_idx)
    );

    // Row select follows the edge currently on coo_in; bad edges read row 0.
    always_comb begin
        mem.read_row = '0;
        unique case (state)
            INIT:     mem.read_row = row_cnt;
            EDGE_SRC: if (edge_ok) mem.read_row = node_row(src);
            EDGE_DST: if (edge_ok) mem.read_row = node_row(dst);
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (start) state_n = INIT;
            INIT:     if (row_last) state_n = EDGE_SRC;
            EDGE_SRC: state_n = EDGE_DST;
            EDGE_DST: state_n = edge_last ? ARGMAX : EDGE_SRC;
            ARGMAX:   if (row_last) state_n = DONE;
            DONE:     if (start) state_n = INIT;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt <= '0;
            edge_cnt <= '0;
            done <= 1'b0;
            coo_err <= 1'b0;
            max_addi_answer <= '0;
            for (int r = 0; r < FEATURE_ROWS; r++) acc[r] <= '0;
        end else begin
            // Registered one cycle behind DONE so a restart drops it a cycle later.
            done <= state == DONE;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        row_cnt <= '0;
                        edge_cnt <= '0;
                        coo_err <= 1'b0;
                        for (int r = 0; r < FEATURE_ROWS; r++) acc[r] <= '0;
                    end
                end
                INIT: begin
                    acc[row_cnt] <= mem.fm_wm_row_in;
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end
                EDGE_SRC: begin
                    if (edge_ok)
                        acc[node_row(dst)] <= add_row(acc[node_row(dst)], mem.fm_wm_row_in);
                    else
                        coo_err <= 1'b1;
                end
                EDGE_DST: begin
                    if (edge_ok)
                        acc[node_row(src)] <= add_row(acc[node_row(src)], mem.fm_wm_row_in);
                    else
                        coo_err <= 1'b1;
                    edge_cnt <= edge_last ? '0 : edge_cnt + 1'b1;
                end
                ARGMAX: begin
                    max_addi_answer[row_cnt] <= argmax_idx;
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aggregation_block.sv
// Directed bench for aggregation_block with behavioural FM_WM and COO memories.
module tb_aggregation_block;
    import gcn_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done;
    logic coo_err;
    class_vec_t ans;

    int checks = 0;
    int errors = 0;

    fm_wm_row_t fm [FEATURE_ROWS];
    coo_pair_t coo [NUM_EDGES];

    aggregation_block_if mif ();

    aggregation_block dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mem             (mif),
        .done            (done),
        .coo_err         (coo_err),
        .max_addi_answer (ans)
    );

    always #5 clk = ~clk;

    always_comb begin
        mif.fm_wm_row_in = '0;
        mif.coo_in = '0;
        if (int'(mif.read_row) < FEATURE_ROWS) mif.fm_wm_row_in = fm[mif.read_row];
        if (int'(mif.coo_address) < NUM_EDGES) mif.coo_in = coo[mif.coo_address];
    end

    function automatic fm_wm_row_t mk_row(int c0, int c1, int c2);
        fm_wm_row_t r;
        r[0] = dot_t'(c0);
        r[1] = dot_t'(c1);
        r[2] = dot_t'(c2);
        return r;
    endfunction

    function automatic coo_pair_t mk_edge(int s, int d);
        coo_pair_t e;
        e[1] = COO_BW'(s);
        e[0] = COO_BW'(d);
        return e;
    endfunction

    function automatic class_vec_t mk_ans(int a0, int a1, int a2, int a3, int a4, int a5);
        class_vec_t v;
        v[0] = class_t'(a0);
        v[1] = class_t'(a1);
        v[2] = class_t'(a2);
        v[3] = class_t'(a3);
        v[4] = class_t'(a4);
        v[5] = class_t'(a5);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulses start, returns the edge count (after the start edge) at which done is seen.
    task automatic run_agg(input int ign_at, output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == ign_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic load_path();
        for (int r = 0; r < FEATURE_ROWS; r++) fm[r] = mk_row(4 * r, 12, 10 - r);
        coo[0] = mk_edge(1, 2);
        coo[1] = mk_edge(2, 3);
        coo[2] = mk_edge(3, 4);
        coo[3] = mk_edge(4, 5);
        coo[4] = mk_edge(5, 6);
        coo[5] = mk_edge(6, 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (coo_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_coo_err got=%b exp=0", coo_err);
        end
        checks++;
        if (mif.read_row !== '0) begin
            errors++;
            $display("FAIL reset_read_row got=%0d exp=0", mif.read_row);
        end
        checks++;
        if (mif.coo_address !== '0) begin
            errors++;
            $display("FAIL reset_coo_address got=%0d exp=0", mif.coo_address);
        end
        checks++;
        if (ans !== '0) begin
            errors++;
            $display("FAIL reset_answer got=%h exp=0", ans);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_self_loop();
        int lat;
        do_reset();
        fm[0] = mk_row(1, 5, 2);
        for (int r = 1; r < FEATURE_ROWS; r++) fm[r] = mk_row(3, 0, 0);
        for (int e = 0; e < NUM_EDGES; e++) coo[e] = mk_edge(1, 1);
        run_agg(0, lat);
        checks++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL self_loop_latency got=%0d exp=25", lat);
        end
        checks++;
        if (ans !== mk_ans(1, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL self_loop_answer got=%h exp=%h", ans, mk_ans(1, 0, 0, 0, 0, 0));
        end
        checks++;
        if (coo_err !== 1'b0) begin
            errors++;
            $display("FAIL self_loop_coo_err got=%b exp=0", coo_err);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL self_loop_done_held got=%b exp=1", done);
        end
    endtask

    task automatic test_path();
        int lat;
        do_reset();
        load_path();
        run_agg(0, lat);
        checks++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL path_latency got=%0d exp=25", lat);
        end
        checks++;
        if (ans !== mk_ans(1, 1, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL path_answer got=%h exp=%h", ans, mk_ans(1, 1, 1, 0, 0, 0));
        end
        checks++;
        if (mif.read_row !== '0 || mif.coo_address !== '0) begin
            errors++;
            $display("FAIL path_idle_addr got=%0d/%0d exp=0/0", mif.read_row, mif.coo_address);
        end
    endtask

    task automatic test_restart();
        int lat;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done_hold got=%b exp=1", done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL restart_done_drop got=%b exp=0", done);
        end
        lat = -1;
        for (int n = 2; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL restart_latency got=%0d exp=25", lat);
        end
        checks++;
        if (ans !== mk_ans(1, 1, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL restart_answer got=%h exp=%h", ans, mk_ans(1, 1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_tie_overflow();
        int lat;
        do_reset();
        fm[0] = mk_row(7, 7, 2);
        fm[1] = mk_row(2, 9, 9);
        fm[2] = mk_row(16'hFFFF, 0, 0);
        fm[3] = mk_row(16'h0002, 0, 5);
        fm[4] = mk_row(0, 0, 0);
        fm[5] = mk_row(0, 0, 0);
        coo[0] = mk_edge(3, 4);
        for (int e = 1; e < NUM_EDGES; e++) coo[e] = mk_edge(5, 6);
        run_agg(0, lat);
        checks++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL tie_latency got=%0d exp=25", lat);
        end
        checks++;
        if (ans !== mk_ans(0, 1, 2, 2, 0, 0)) begin
            errors++;
            $display("FAIL tie_overflow_answer got=%h exp=%h", ans, mk_ans(0, 1, 2, 2, 0, 0));
        end
        checks++;
        if (coo_err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_coo_err got=%b exp=0", coo_err);
        end
    endtask

    task automatic test_bad_index();
        int lat;
        do_reset();
        fm[0] = mk_row(1, 0, 0);
        fm[1] = mk_row(0, 2, 0);
        fm[2] = mk_row(0, 0, 9);
        for (int r = 3; r < FEATURE_ROWS; r++) fm[r] = mk_row(0, 0, 0);
        coo[0] = mk_edge(0, 3);
        coo[1] = mk_edge(1, 2);
        coo[2] = mk_edge(3, 3);
        for (int e = 3; e < NUM_EDGES; e++) coo[e] = mk_edge(5, 6);
        run_agg(0, lat);
        checks++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL bad_index_latency got=%0d exp=25", lat);
        end
        checks++;
        if (ans !== mk_ans(1, 1, 2, 0, 0, 0)) begin
            errors++;
            $display("FAIL bad_index_answer got=%h exp=%h", ans, mk_ans(1, 1, 2, 0, 0, 0));
        end
        checks++;
        if (coo_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_index_coo_err got=%b exp=1", coo_err);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset();
        load_path();
        run_agg(0, lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (mif.read_row !== row_idx_t'(2) || mif.coo_address !== EDGE_ADDR_WIDTH'(1)) begin
            errors++;
            $display("FAIL edge_dst_addr got=%0d/%0d exp=2/1", mif.read_row, mif.coo_address);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ans !== '0 || done !== 1'b0 || coo_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h/%b/%b exp=0/0/0", ans, done, coo_err);
        end
        checks++;
        if (mif.read_row !== '0 || mif.coo_address !== '0) begin
            errors++;
            $display("FAIL mid_reset_addr got=%0d/%0d exp=0/0", mif.read_row, mif.coo_address);
        end
        @(negedge clk);
        reset = 1'b0;
        run_agg(7, lat);
        checks++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL ignored_start_latency got=%0d exp=25", lat);
        end
        checks++;
        if (ans !== mk_ans(1, 1, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL fresh_run_answer got=%h exp=%h", ans, mk_ans(1, 1, 1, 0, 0, 0));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int r = 0; r < FEATURE_ROWS; r++) fm[r] = '0;
        for (int e = 0; e < NUM_EDGES; e++) coo[e] = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_self_loop();
        test_path();
        test_restart();
        test_tie_overflow();
        test_bad_index();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
